timer_ctrl: RTL and testbench

- Control FSM that sequences the BCD MM:SS stopwatch timer core.
- Turns raw start/stop, lap and clear buttons into the core's `rstn` and `actv` controls.
- Selects a live or lap-frozen display value.
- Raises an alarm and stops the core when a programmable limit is reached.
- Sits between board push-buttons and the timer core; its display output feeds the 7-segment driver.

---
 rtl/timer_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_timer_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Control FSM for the BCD MM:SS stopwatch core: button conditioning, run/pause/lap/alarm sequencing.
// Defining TIMER_CTRL_DEBOUNCE_EN inserts a DB_CYC-sample debouncer after each button synchronizer.
module timer_ctrl #(
    parameter logic [15:0] LIMIT_BCD = 16'h5959,
    parameter int          CLR_CYC   = 4,
    parameter int          DB_CYC    = 16
) (
    input  logic        CLK,
    input  logic        rstn,
    input  logic        btn_ss,
    input  logic        btn_lap,
    input  logic        btn_clr,
    input  logic [15:0] bcd_tim,
    output logic        tim_rstn,
    output logic        tim_actv,
    output logic [15:0] disp_bcd,
    output logic        running,
    output logic        alarm
);
    localparam int CntW = $clog2(CLR_CYC);

    if (CLR_CYC < 2 || DB_CYC < 1) begin : g_bad_params
        $error("timer_ctrl: CLR_CYC must be at least 2 and DB_CYC at least 1");
    end

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_RUN,
        S_LAP,
        S_PAUSE,
        S_ALARM
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            actv_nxt;
    logic            lap_load;
    logic            clr_done;
    logic [CntW-1:0] clr_cnt;
    logic [15:0]     lap_reg;

    logic [2:0] btn_raw;
    logic [2:0] btn_meta;
    logic [2:0] btn_sync;
    logic [2:0] btn_lvl;
    logic [2:0] btn_lvl_q;
    logic [2:0] btn_evt;
    logic       ev_ss;
    logic       ev_lap;
    logic       ev_clr;

    assign btn_raw = {btn_clr, btn_lap, btn_ss};

    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
        end
    end

`ifdef TIMER_CTRL_DEBOUNCE_EN
    localparam int DbW = $clog2(DB_CYC + 1);

    // The level only follows the synchronized input after DB_CYC consecutive differing samples.
    for (genvar i = 0; i < 3; i++) begin : g_db
        logic [DbW-1:0] db_cnt;
        logic           db_lvl;

        always_ff @(posedge CLK or negedge rstn) begin
            if (!rstn) begin
                db_cnt <= '0;
                db_lvl <= 1'b0;
            end else if (btn_sync[i] == db_lvl) begin
                db_cnt <= '0;
            end else if (db_cnt == DbW'(DB_CYC - 1)) begin
                db_cnt <= '0;
                db_lvl <= btn_sync[i];
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end

        assign btn_lvl[i] = db_lvl;
    end
`else
    assign btn_lvl = btn_sync;
`endif

    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            btn_lvl_q <= '0;
            btn_evt   <= '0;
        end else begin
            btn_lvl_q <= btn_lvl;
            btn_evt   <= btn_lvl & ~btn_lvl_q;
        end
    end

    assign ev_ss    = btn_evt[0];
    assign ev_lap   = btn_evt[1];
    assign ev_clr   = btn_evt[2];
    assign clr_done = (clr_cnt == CntW'(CLR_CYC - 1));

    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Priority inside each state: clr, then the limit compare, then ss, then lap.
    always_comb begin
        state_nxt = state;
        actv_nxt  = 1'b0;
        lap_load  = 1'b0;
        case (state)
            S_CLEAR: begin
                if (clr_done) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE, S_PAUSE: begin
                if (ev_clr) begin
                    state_nxt = S_CLEAR;
                end else if (ev_ss) begin
                    state_nxt = S_RUN;
                    actv_nxt  = 1'b1;
                end
            end
            S_RUN, S_LAP: begin
                if (ev_clr) begin
                    state_nxt = S_CLEAR;
                end else if (bcd_tim == LIMIT_BCD) begin
                    state_nxt = S_ALARM;
                    actv_nxt  = 1'b1;
                end else if (ev_ss) begin
                    state_nxt = S_PAUSE;
                    actv_nxt  = 1'b1;
                end else if (ev_lap) begin
                    if (state == S_RUN) begin
                        state_nxt = S_LAP;
                        lap_load  = 1'b1;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
            end
            S_ALARM: begin
                if (ev_clr || ev_ss) begin
                    state_nxt = S_CLEAR;
                end
            end
            default: begin
                state_nxt = S_CLEAR;
            end
        endcase
    end

    // Core controls track the next state; display flags follow the current state one cycle later.
    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            tim_rstn <= 1'b0;
            tim_actv <= 1'b0;
            disp_bcd <= 16'h0000;
            running  <= 1'b0;
            alarm    <= 1'b0;
            lap_reg  <= 16'h0000;
            clr_cnt  <= '0;
        end else begin
            tim_rstn <= (state_nxt != S_CLEAR);
            tim_actv <= actv_nxt;
            running  <= (state == S_RUN) || (state == S_LAP);
            alarm    <= (state == S_ALARM);
            if (lap_load) begin
                lap_reg <= bcd_tim;
            end
            if (state == S_CLEAR && !clr_done) begin
                clr_cnt <= clr_cnt + 1'b1;
            end else begin
                clr_cnt <= '0;
            end
            case (state)
                S_CLEAR: disp_bcd <= 16'h0000;
                S_LAP:   disp_bcd <= lap_reg;
                S_ALARM: disp_bcd <= LIMIT_BCD;
                default: disp_bcd <= bcd_tim;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed scoreboard bench for timer_ctrl in its default build (CLR_CYC=4, LIMIT_BCD=16'h5959).
`timescale 1ns/1ps
module tb_timer_ctrl;
    localparam int WIN = 16;
    localparam int CLR = 4;

    logic        CLK = 1'b0;
    logic        rstn;
    logic        btn_ss;
    logic        btn_lap;
    logic        btn_clr;
    logic [15:0] bcd_tim;
    logic        tim_rstn;
    logic        tim_actv;
    logic [15:0] disp_bcd;
    logic        running;
    logic        alarm;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string tag;
        int    pulses;
        int    delay;
        int    rstn_low;
    } evt_t;

    typedef struct {
        string       tag;
        logic        rstn_e;
        logic        actv_e;
        logic        run_e;
        logic        alarm_e;
        logic [15:0] disp_e;
    } lvl_t;

    evt_t evt_q[$];
    lvl_t lvl_q[$];

    timer_ctrl dut (
        .CLK      (CLK),
        .rstn     (rstn),
        .btn_ss   (btn_ss),
        .btn_lap  (btn_lap),
        .btn_clr  (btn_clr),
        .bcd_tim  (bcd_tim),
        .tim_rstn (tim_rstn),
        .tim_actv (tim_actv),
        .disp_bcd (disp_bcd),
        .running  (running),
        .alarm    (alarm)
    );

    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic expectLevels(input string tag, input logic r, input logic a, input logic run,
                                input logic al, input logic [15:0] disp);
        lvl_q.push_back('{tag: tag, rstn_e: r, actv_e: a, run_e: run, alarm_e: al, disp_e: disp});
    endtask

    task automatic checkOutput();
        lvl_t e;
        checkVal("lvl_queue_nonempty", 16'(lvl_q.size() != 0), 16'd1);
        if (lvl_q.size() != 0) begin
            e = lvl_q.pop_front();
            checkVal({e.tag, "_tim_rstn"}, 16'(tim_rstn), 16'(e.rstn_e));
            checkVal({e.tag, "_tim_actv"}, 16'(tim_actv), 16'(e.actv_e));
            checkVal({e.tag, "_running"},  16'(running),  16'(e.run_e));
            checkVal({e.tag, "_alarm"},    16'(alarm),    16'(e.alarm_e));
            checkVal({e.tag, "_disp_bcd"}, disp_bcd,      e.disp_e);
        end
    endtask

    // Press the masked buttons ({clr,lap,ss}) for 3 cycles and watch a fixed window of cycles.
    task automatic applyStimulus(input string tag, input logic [2:0] mask, input logic [15:0] bcd_set,
                                 input int exp_pulses, input int exp_delay, input int exp_rstn_low);
        int   pulses;
        int   delay;
        int   rstn_low;
        evt_t e;
        evt_q.push_back('{tag: tag, pulses: exp_pulses, delay: exp_delay, rstn_low: exp_rstn_low});
        pulses   = 0;
        delay    = 0;
        rstn_low = 0;
        @(negedge CLK);
        {btn_clr, btn_lap, btn_ss} = mask;
        bcd_tim = bcd_set;
        for (int i = 1; i <= WIN; i++) begin
            @(posedge CLK);
            #1;
            if (tim_actv === 1'b1) begin
                pulses++;
                if (delay == 0) delay = i;
            end
            if (tim_rstn !== 1'b1) rstn_low++;
            if (i == 3) {btn_clr, btn_lap, btn_ss} = 3'b000;
        end
        e = evt_q.pop_front();
        checkVal({e.tag, "_actv_pulses"}, 16'(pulses),   16'(e.pulses));
        checkVal({e.tag, "_actv_delay"},  16'(delay),    16'(e.delay));
        checkVal({e.tag, "_rstn_low"},    16'(rstn_low), 16'(e.rstn_low));
    endtask

    task automatic measureRelease(input string tag);
        int first_high;
        first_high = 0;
        @(negedge CLK);
        rstn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge CLK);
            #1;
            if (tim_rstn === 1'b1 && first_high == 0) first_high = k;
        end
        checkVal({tag, "_release_cycles"}, 16'(first_high), 16'(CLR));
    endtask

    initial begin
        rstn    = 1'b0;
        btn_ss  = 1'b0;
        btn_lap = 1'b0;
        btn_clr = 1'b0;
        bcd_tim = 16'h0042;

        waitCycles(3);
        expectLevels("reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput();

        measureRelease("por");
        expectLevels("idle", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0042);
        checkOutput();

        applyStimulus("idle_lap", 3'b010, 16'h0042, 0, 0, 0);
        expectLevels("idle_lap", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0042);
        checkOutput();

        applyStimulus("idle_ss", 3'b001, 16'h0042, 1, 4, 0);
        expectLevels("run", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0042);
        checkOutput();

        applyStimulus("run_ss", 3'b001, 16'h0042, 1, 4, 0);
        expectLevels("pause", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0042);
        checkOutput();

        applyStimulus("pause_ss", 3'b001, 16'h0100, 1, 4, 0);
        applyStimulus("run_lap", 3'b010, 16'h0123, 0, 0, 0);
        @(negedge CLK);
        bcd_tim = 16'h0130;
        waitCycles(2);
        expectLevels("lap_frozen", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0123);
        checkOutput();

        applyStimulus("lap_lap", 3'b010, 16'h0130, 0, 0, 0);
        expectLevels("lap_live", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0130);
        checkOutput();

        applyStimulus("limit", 3'b000, 16'h5959, 1, 1, 0);
        expectLevels("alarm", 1'b1, 1'b0, 1'b0, 1'b1, 16'h5959);
        checkOutput();

        applyStimulus("alarm_ss", 3'b001, 16'h0000, 0, 0, CLR);
        expectLevels("alarm_cleared", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput();

        applyStimulus("idle_ss2", 3'b001, 16'h0077, 1, 4, 0);
        applyStimulus("run_clr_ss", 3'b101, 16'h0077, 0, 0, CLR);
        expectLevels("clr_ss_idle", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0077);
        checkOutput();

        applyStimulus("idle_ss3", 3'b001, 16'h0077, 1, 4, 0);
        @(negedge CLK);
        rstn = 1'b0;
        waitCycles(2);
        expectLevels("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput();
        measureRelease("mid");
        expectLevels("mid_idle", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0077);
        checkOutput();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
